// File: rtl/mem_initiator_pkg.sv
// Shared encodings for the load/store memory initiator: access sizes, FSM states
// and the big-endian lane position helper.
package mem_initiator_pkg;

    localparam int DATA_W = 32;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CAP,
        WR,
        RESP
    } state_t;

    // Bit position of the LSB of the addressed lane; byte k sits at [31-8k -: 8].
    function automatic logic [4:0] lane_shift(input logic [1:0] offset, input logic [1:0] size);
        logic [4:0] shift;
        case (size)
            SZ_BYTE: shift = {~offset, 3'b000};
            SZ_HALF: shift = {~offset[1], 4'b0000};
            default: shift = 5'd0;
        endcase
        return shift;
    endfunction

endpackage

// File: rtl/mem_initiator_if.sv
// Request/response handshake and single-port memory bus of the load/store initiator.
interface mem_initiator_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_sign;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;

    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    logic              mem_cs;
    logic              mem_oe;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_din;
    logic [31:0]       mem_dout;

    modport master (
        input  req_valid, req_we, req_size, req_sign, req_addr, req_wdata, mem_dout,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_cs, mem_oe, mem_we, mem_addr, mem_din
    );

    modport slave (
        output req_valid, req_we, req_size, req_sign, req_addr, req_wdata, mem_dout,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_cs, mem_oe, mem_we, mem_addr, mem_din
    );

endinterface

// File: rtl/mem_lane_unit.sv
// Combinational big-endian lane logic: load extraction/extension, sub-word merge
// and the alignment/size legality check.
module mem_lane_unit
    import mem_initiator_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        sign,
    input  logic [15:0] wdata,
    output logic [31:0] load_val,
    output logic [31:0] merged,
    output logic        misalign
);

    logic [4:0]  shift;
    logic [15:0] lane;

    always_comb begin
        shift    = lane_shift(offset, size);
        lane     = 16'(rdata >> shift);
        load_val = rdata;
        merged   = rdata;
        misalign = 1'b0;
        case (size)
            SZ_BYTE: begin
                load_val = {{24{sign & lane[7]}}, lane[7:0]};
                merged   = (rdata & ~(32'h0000_00FF << shift)) | ({24'h0, wdata[7:0]} << shift);
            end
            SZ_HALF: begin
                load_val = {{16{sign & lane[15]}}, lane};
                merged   = (rdata & ~(32'h0000_FFFF << shift)) | ({16'h0, wdata} << shift);
                misalign = offset[0];
            end
            SZ_WORD: begin
                misalign = |offset;
            end
            default: begin
                misalign = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/mem_initiator.sv
// Load/store bus initiator: one request at a time, word-aligned memory cycles,
// read-modify-write for sub-word stores and a one-cycle response pulse.
module mem_initiator
    import mem_initiator_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic clk,
    input  logic reset,
    mem_initiator_if.master bus
);

    state_t            state, state_next;
    logic              store_q, sign_q, err_q;
    logic [1:0]        size_q, off_q;
    logic [15:0]       wdata_q;
    logic [31:0]       rdata_q, din_q;
    logic [ADDR_W-1:0] addr_q;

    logic              accept;
    logic [1:0]        lane_off, lane_size;
    logic [31:0]       load_val, merged;
    logic              misalign;
    logic              ready, cs, oe, we, rsp;

    // The lane unit checks the live request in IDLE and works on the latched one afterwards.
    assign lane_off  = (state == IDLE) ? bus.req_addr[1:0] : off_q;
    assign lane_size = (state == IDLE) ? bus.req_size : size_q;
    assign accept    = (state == IDLE) && bus.req_valid;

    mem_lane_unit u_lane (
        .rdata    (bus.mem_dout),
        .offset   (lane_off),
        .size     (lane_size),
        .sign     (sign_q),
        .wdata    (wdata_q),
        .load_val (load_val),
        .merged   (merged),
        .misalign (misalign)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ready      = 1'b0;
        cs         = 1'b0;
        oe         = 1'b0;
        we         = 1'b0;
        rsp        = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (bus.req_valid) begin
                    if (misalign) begin
                        state_next = RESP;
                    end else if (bus.req_we && bus.req_size == SZ_WORD) begin
                        state_next = WR;
                    end else begin
                        state_next = RD;
                    end
                end
            end
            RD: begin
                cs         = 1'b1;
                oe         = 1'b1;
                state_next = CAP;
            end
            CAP: begin
                state_next = store_q ? WR : RESP;
            end
            WR: begin
                cs         = 1'b1;
                we         = 1'b1;
                state_next = RESP;
            end
            RESP: begin
                rsp        = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request fields are captured once at acceptance; CAP fills either the load result or the merged word.
    always_ff @(posedge clk) begin
        if (reset) begin
            store_q <= 1'b0;
            sign_q  <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= SZ_BYTE;
            off_q   <= 2'b00;
            wdata_q <= '0;
            rdata_q <= '0;
            din_q   <= '0;
            addr_q  <= '0;
        end else begin
            if (accept) begin
                store_q <= bus.req_we;
                sign_q  <= bus.req_sign;
                size_q  <= bus.req_size;
                off_q   <= bus.req_addr[1:0];
                wdata_q <= bus.req_wdata[15:0];
                err_q   <= misalign;
                rdata_q <= '0;
                if (!misalign) begin
                    addr_q <= {bus.req_addr[ADDR_W-1:2], 2'b00};
                    if (bus.req_we && bus.req_size == SZ_WORD) begin
                        din_q <= bus.req_wdata;
                    end
                end
            end
            if (state == CAP) begin
                if (store_q) begin
                    din_q <= merged;
                end else begin
                    rdata_q <= load_val;
                end
            end
        end
    end

    assign bus.req_ready = ready;
    assign bus.mem_cs    = cs;
    assign bus.mem_oe    = oe;
    assign bus.mem_we    = we;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_din   = din_q;
    assign bus.rsp_valid = rsp;
    assign bus.rsp_err   = rsp & err_q;
    assign bus.rsp_rdata = rdata_q;

endmodule

// File: tb/tb_mem_initiator.sv
// Randomised and directed bench for mem_initiator against a byte-array memory model.
module tb_mem_initiator;

    logic clk = 1'b0;
    logic reset;
    logic preload;
    logic [31:0] init_words [64];
    logic [31:0] ram [64];
    logic [7:0]  refmem [256];
    int tests    = 0;
    int failures = 0;
    int oe_we_both = 0;

    mem_initiator_if #(.ADDR_W(32)) bus ();

    mem_initiator #(.ADDR_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    // Synchronous memory: read data registered on cs&oe, write on cs&we.
    always @(posedge clk) begin
        if (preload) begin
            for (int w = 0; w < 64; w++) ram[w] <= init_words[w];
        end else begin
            if (bus.mem_cs && bus.mem_oe) bus.mem_dout <= ram[bus.mem_addr[7:2]];
            if (bus.mem_cs && bus.mem_we) ram[bus.mem_addr[7:2]] <= bus.mem_din;
        end
    end

    always @(negedge clk) begin
        if (bus.mem_oe && bus.mem_we) oe_we_both++;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation still running, required finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit refErr(input logic [1:0] size, input logic [7:0] a);
        return (size == 2'b11) || (size == 2'b01 && a[0]) || (size == 2'b10 && a[1:0] != 2'b00);
    endfunction

    function automatic logic [31:0] refWord(input logic [7:0] a);
        int b = {a[7:2], 2'b00};
        return {refmem[b], refmem[b+1], refmem[b+2], refmem[b+3]};
    endfunction

    function automatic logic [31:0] refLoad(input logic [1:0] size, input logic sign, input logic [7:0] a);
        logic [7:0]  bv;
        logic [15:0] hv;
        int i = a;
        if (size == 2'b00) begin
            bv = refmem[i];
            return sign ? {{24{bv[7]}}, bv} : {24'h0, bv};
        end else if (size == 2'b01) begin
            hv = {refmem[i], refmem[i+1]};
            return sign ? {{16{hv[15]}}, hv} : {16'h0, hv};
        end
        return refWord(a);
    endfunction

    task automatic refStore(input logic [1:0] size, input logic [7:0] a, input logic [31:0] d);
        int i = a;
        if (size == 2'b00) begin
            refmem[i] = d[7:0];
        end else if (size == 2'b01) begin
            refmem[i]   = d[15:8];
            refmem[i+1] = d[7:0];
        end else begin
            refmem[i]   = d[31:24];
            refmem[i+1] = d[23:16];
            refmem[i+2] = d[15:8];
            refmem[i+3] = d[7:0];
        end
    endtask

    task automatic driveReq(input logic we, input logic [1:0] size, input logic sign,
                            input logic [7:0] addr, input logic [31:0] wdata);
        bus.req_we    = we;
        bus.req_size  = size;
        bus.req_sign  = sign;
        bus.req_addr  = {24'h0, addr};
        bus.req_wdata = wdata;
    endtask

    // One complete transaction with latency, strobe counts and data compared to the byte model.
    task automatic applyStimulus(input logic we, input logic [1:0] size, input logic sign,
                                 input logic [7:0] addr, input logic [31:0] wdata);
        int lat = 0, nrd = 0, nwr = 0, waited = 0;
        int exp_lat, exp_rd, exp_wr;
        logic [31:0] got_rdata = '0, got_din = '0, got_addr = '0, exp_rdata = '0, exp_din = '0;
        logic got_err = 1'b0, exp_err;
        exp_err = refErr(size, addr);
        if (exp_err) begin
            exp_lat = 1; exp_rd = 0; exp_wr = 0;
        end else if (!we) begin
            exp_lat = 3; exp_rd = 1; exp_wr = 0;
            exp_rdata = refLoad(size, sign, addr);
        end else begin
            refStore(size, addr, wdata);
            exp_din = refWord(addr);
            exp_wr  = 1;
            exp_rd  = (size == 2'b10) ? 0 : 1;
            exp_lat = (size == 2'b10) ? 2 : 4;
        end
        @(negedge clk);
        driveReq(we, size, sign, addr, wdata);
        bus.req_valid = 1'b1;
        while (!bus.req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 20) checkOutput("ready_timeout", 32'(waited), 32'd0);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        driveReq($urandom_range(0, 1), 2'($urandom), 1'($urandom), 8'($urandom), $urandom);
        for (int c = 1; c <= 20 && lat == 0; c++) begin
            @(negedge clk);
            if (bus.mem_cs && bus.mem_oe) begin nrd++; got_addr = bus.mem_addr; end
            if (bus.mem_cs && bus.mem_we) begin nwr++; got_din = bus.mem_din; got_addr = bus.mem_addr; end
            if (bus.rsp_valid) begin
                lat       = c;
                got_rdata = bus.rsp_rdata;
                got_err   = bus.rsp_err;
            end
        end
        checkOutput("latency", 32'(lat), 32'(exp_lat));
        checkOutput("rsp_err", {31'h0, got_err}, {31'h0, exp_err});
        checkOutput("rsp_rdata", got_rdata, exp_rdata);
        checkOutput("rd_cycles", 32'(nrd), 32'(exp_rd));
        checkOutput("wr_cycles", 32'(nwr), 32'(exp_wr));
        if (exp_wr != 0) checkOutput("wr_data", got_din, exp_din);
        if (exp_rd + exp_wr != 0) checkOutput("mem_addr", got_addr, {24'h0, addr[7:2], 2'b00});
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_rsp_valid"}, {31'h0, bus.rsp_valid}, 32'h0);
        checkOutput({tag, "_rsp_err"}, {31'h0, bus.rsp_err}, 32'h0);
        checkOutput({tag, "_rsp_rdata"}, bus.rsp_rdata, 32'h0);
        checkOutput({tag, "_strobes"}, {29'h0, bus.mem_cs, bus.mem_oe, bus.mem_we}, 32'h0);
        checkOutput({tag, "_mem_addr"}, bus.mem_addr, 32'h0);
        checkOutput({tag, "_mem_din"}, bus.mem_din, 32'h0);
        checkOutput({tag, "_req_ready"}, {31'h0, bus.req_ready}, 32'h1);
    endtask

    // Reset while an sh 0x10 sits in CAP must abandon the write entirely.
    task automatic resetInCap();
        int writes = 0;
        @(negedge clk);
        driveReq(1'b1, 2'b01, 1'b0, 8'h10, 32'h0000_1234);
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        if (bus.mem_we) writes++;
        @(negedge clk);
        if (bus.mem_we) writes++;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkIdleOutputs("cap_reset");
        for (int c = 0; c < 4; c++) begin
            if (bus.mem_we) writes++;
            @(negedge clk);
        end
        checkOutput("cap_reset_writes", 32'(writes), 32'h0);
    endtask

    // Three loads with req_valid held high: acceptances every four cycles.
    task automatic queuedLoads();
        logic [1:0]  sz [3] = '{2'b10, 2'b00, 2'b01};
        logic [7:0]  ad [3] = '{8'h10, 8'h11, 8'h22};
        logic        sg [3] = '{1'b0, 1'b1, 1'b0};
        int acc_c [$];
        int rsp_c [$];
        logic [31:0] rsp_d [$];
        int idx = 0, ready_cnt = 0;
        bit accepted;
        @(negedge clk);
        driveReq(1'b0, sz[0], sg[0], ad[0], 32'h0);
        bus.req_valid = 1'b1;
        for (int c = 0; c < 16; c++) begin
            accepted = bus.req_ready && bus.req_valid;
            if (accepted) acc_c.push_back(c);
            if (c < 12 && bus.req_ready) ready_cnt++;
            if (bus.rsp_valid) begin
                rsp_c.push_back(c);
                rsp_d.push_back(bus.rsp_rdata);
            end
            @(posedge clk);
            #1;
            if (accepted) begin
                idx++;
                if (idx < 3) driveReq(1'b0, sz[idx], sg[idx], ad[idx], 32'h0);
                else bus.req_valid = 1'b0;
            end
            @(negedge clk);
        end
        checkOutput("q_accept_count", 32'(acc_c.size()), 32'd3);
        checkOutput("q_rsp_count", 32'(rsp_c.size()), 32'd3);
        checkOutput("q_ready_cycles", 32'(ready_cnt), 32'd3);
        for (int i = 0; i < 3 && i < acc_c.size(); i++) checkOutput("q_accept_cycle", 32'(acc_c[i]), 32'(4 * i));
        for (int i = 0; i < 3 && i < rsp_c.size(); i++) begin
            checkOutput("q_rsp_cycle", 32'(rsp_c[i]), 32'(4 * i + 3));
            checkOutput("q_rsp_rdata", rsp_d[i], refLoad(sz[i], sg[i], ad[i]));
        end
    endtask

    initial begin
        reset = 1'b1;
        preload = 1'b1;
        bus.req_valid = 1'b0;
        driveReq(1'b0, 2'b00, 1'b0, 8'h00, 32'h0);
        for (int w = 0; w < 64; w++) init_words[w] = $urandom;
        init_words[4] = 32'h8899_AABB;
        for (int w = 0; w < 64; w++) begin
            refmem[4*w]   = init_words[w][31:24];
            refmem[4*w+1] = init_words[w][23:16];
            refmem[4*w+2] = init_words[w][15:8];
            refmem[4*w+3] = init_words[w][7:0];
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        preload = 1'b0;
        @(negedge clk);
        checkIdleOutputs("reset");

        applyStimulus(1'b0, 2'b10, 1'b0, 8'h10, 32'h0);
        applyStimulus(1'b0, 2'b00, 1'b1, 8'h11, 32'h0);
        applyStimulus(1'b0, 2'b00, 1'b0, 8'h13, 32'h0);
        applyStimulus(1'b0, 2'b01, 1'b1, 8'h12, 32'h0);
        applyStimulus(1'b0, 2'b01, 1'b0, 8'h10, 32'h0);
        applyStimulus(1'b1, 2'b00, 1'b0, 8'h12, 32'h0000_00CC);
        applyStimulus(1'b0, 2'b10, 1'b0, 8'h10, 32'h0);
        checkOutput("sb_merge_model", refWord(8'h10), 32'h8899_CCBB);
        applyStimulus(1'b1, 2'b10, 1'b0, 8'h11, 32'hDEAD_BEEF);
        applyStimulus(1'b0, 2'b01, 1'b0, 8'h13, 32'h0);
        applyStimulus(1'b1, 2'b11, 1'b0, 8'h10, 32'h1234_5678);
        applyStimulus(1'b0, 2'b10, 1'b0, 8'h10, 32'h0);

        resetInCap();
        applyStimulus(1'b0, 2'b10, 1'b0, 8'h10, 32'h0);

        queuedLoads();

        for (int n = 0; n < 80; n++) begin
            applyStimulus(1'($urandom), 2'($urandom), 1'($urandom),
                          8'($urandom_range(0, 255)), $urandom);
        end

        checkOutput("oe_we_exclusive", 32'(oe_we_both), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/mem_initiator.md
# mem_initiator

Bus initiator that drives the single-port synchronous data memory (cs/oe/we/addr/din/dout) on behalf of the processor's load/store path. It accepts one load or store request at a time through a valid/ready handshake and issues word-aligned memory cycles. It performs big-endian byte/halfword extraction with sign or zero extension, and read-modify-write for sub-word stores. It returns a one-cycle response pulse carrying load data or a misalignment error.

## Interface
- ADDR_W, 32, byte-address width; data width is fixed at 32.
- clk  in  1  clock; all state changes on posedge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; a request is accepted on a posedge with req_valid & req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word; 11 is treated as an error.
- req_sign  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-justified.
- rsp_valid  out  1  one-cycle completion pulse; there is no backpressure.
- rsp_rdata  out  32  load result; 0 for stores and errors.
- rsp_err  out  1  misaligned access or bad size; valid with rsp_valid.
- mem_cs, mem_oe, mem_we  out  1 each  memory strobes.
- mem_addr  out  ADDR_W  word address (req_addr with bits [1:0] forced to 0).
- mem_din  out  32  write data.
- mem_dout  in  32  read data; registered by the memory on the posedge that samples cs & oe.

## Operation
- Request fields are latched on acceptance and are not sampled again.
- Error check at acceptance:
  - half with addr[0]=1 is an error;
  - word with addr[1:0]≠0 is an error;
  - size 11 is an error.
  - An error goes IDLE→RESP with rsp_err=1, and no memory strobe is ever asserted.
- State machine (Moore; strobes decoded from state):
  - IDLE: accept. Load → RD. Word store → WR. Sub-word store → RD (rmw flag set).
  - RD: mem_cs=1, mem_oe=1. → CAP.
  - CAP: mem_dout is valid.
    - Load: register the extracted and extended value into rsp_rdata, → RESP.
    - rmw: register the merged word into mem_din, → WR.
  - WR: mem_cs=1, mem_we=1, mem_din stable. → RESP.
  - RESP: rsp_valid=1. → IDLE.
- Lane mapping is big-endian: byte at offset k occupies bits [31-8k -: 8]; half at offset 0 → [31:16], offset 2 → [15:0].
- Merge: replace only the addressed lane with req_wdata[7:0] or [15:0]; all other lanes keep the read value.
- Extension: sign-extend from bit 7 or bit 15 when req_sign=1, else zero-fill. Word loads ignore req_sign.
- mem_addr and mem_din hold their values outside strobe cycles. mem_oe and mem_we are never high together.

## Timing
Cycle 0 is the acceptance edge. rsp_valid is high in:
- cycle 3 for any load;
- cycle 2 for a word store;
- cycle 4 for a sub-word store;
- cycle 1 for an error.

req_ready is low from cycle 1 until the state returns to IDLE. The next acceptance is possible at the earliest on the edge one cycle after RESP (back-to-back loads every 4 cycles).

Exactly one RD cycle per load and per RMW; exactly one WR cycle per store.

Reset:
- The state goes to IDLE, and rsp_valid, rsp_err, rsp_rdata, mem_addr, mem_din are cleared to 0. This makes all strobes 0 and req_ready 1 from the cycle after the reset edge.
- Reset has priority over req_valid on the same edge.
- Reset in RD or CAP of an RMW abandons the store: no WR cycle is issued.
- Reset during WR cannot cancel the write already sampled by the memory on that edge.

## Structure
- Package mem_initiator_pkg: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), the state enum (IDLE, RD, CAP, WR, RESP), and a lane-offset helper function.
- Sub-module mem_lane_unit: purely combinational. Inputs: read word, offset, size, sign, wdata. Outputs: extended load value, merged store word, misalign flag. It is shared by the CAP logic and the error check.

## Test plan
Memory model preloaded with word 0x00000010 = 0x8899AABB.
- Load word 0x10 → rsp_valid at cycle 3, rsp_rdata 0x8899AABB; mem_cs&oe high for exactly 1 cycle; mem_addr 0x10.
- Signed lb 0x11 → 0xFFFFFF99; unsigned lb 0x13 → 0x000000BB; signed lh 0x12 → 0xFFFFAABB; unsigned lh 0x10 → 0x00008899.
- sb 0x12 with wdata 0x000000CC → one RD, then one WR with mem_din 0x8899CCBB, rsp_valid at cycle 4, rsp_rdata 0. A following load word 0x10 returns 0x8899CCBB.
- Store word to 0x11, then load half at 0x13 → each gives rsp_err=1 at cycle 1; mem_cs never asserted; memory unchanged.
- Reset asserted while in CAP of sh 0x10 → mem_we never asserted; the following cycle has all outputs 0 and req_ready 1; the memory word is unchanged.
- req_valid held high with 3 queued loads → req_ready low while busy; acceptances at cycles 0, 4, 8; rsp_valid pulses at cycles 3, 7, 11.
